// File: rtl/ingress_pacer_pkg.sv
// Shared types and default constants for the ingress pacer and its FIFO.
package ingress_pacer_pkg;

  localparam int PACER_BYTE_W  = 8;
  localparam int PACER_DEPTH   = 4;
  localparam int PACER_GAP     = 5;
  localparam int PACER_CREDITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } pacer_state_t;

endpackage

// File: rtl/ingress_pacer_fifo.sv
// pacer_fifo: byte store with natural-wrap pointers; push/pop apply at the same edge, head is combinational.
// The owner guarantees no push when full and no pop when empty.
module pacer_fifo
  import ingress_pacer_pkg::*;
#(
  parameter int DEPTH = PACER_DEPTH,
  parameter int W     = PACER_BYTE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;

  // Storage is left unreset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/ingress_pacer.sv
// ingress_pacer: paces FIFO'd bytes to the splitter as m_valid pulses >= GAP cycles apart; issue one edge after accept.
// s_ready = level < DEPTH (no same-cycle pop credit); INGRESS_PACER_CREDIT_EN enables credit gating.
module ingress_pacer
  import ingress_pacer_pkg::*;
#(
  parameter int DEPTH   = PACER_DEPTH,
  parameter int GAP     = PACER_GAP,
  parameter int CREDITS = PACER_CREDITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PACER_BYTE_W-1:0]      s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [PACER_BYTE_W-1:0]      m_data,
  output logic                         m_valid,
  input  logic                         credit_ret,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         err_credit
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int GW = $clog2(GAP);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP - 1);

  pacer_state_t            state;
  logic [GW-1:0]           gap_cnt;
  logic [PACER_BYTE_W-1:0] head;
  logic                    push;
  logic                    credit_ok;
  logic                    can_issue;
  logic                    issue;

  assign s_ready = (fifo_level < LEVEL_FULL);
  assign push    = s_valid && s_ready;

  pacer_fifo #(
    .DEPTH (DEPTH),
    .W     (PACER_BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (issue),
    .head      (head),
    .level     (fifo_level)
  );

  // Only the last HOLD cycle may re-issue, giving back-to-back pulses exactly GAP apart.
  assign can_issue = (fifo_level != '0) && credit_ok;
  assign issue     = can_issue && ((state == IDLE) || (gap_cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            m_data  <= head;
            m_valid <= 1'b1;
            gap_cnt <= GAP_LOAD;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (issue) begin
            m_data  <= head;
            m_valid <= 1'b1;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INGRESS_PACER_CREDIT_EN
  logic [CW-1:0] credits;

  assign credit_ok  = (credits != '0);
  assign credit_cnt = credits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits    <= CREDIT_MAX;
      err_credit <= 1'b0;
    end else begin
      if (credit_ret && (credits == CREDIT_MAX)) begin
        err_credit <= 1'b1;
      end
      case ({issue, credit_ret})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= (credits == CREDIT_MAX) ? credits : credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end
`else
  logic unused_credit_ret;

  assign unused_credit_ret = credit_ret;
  assign credit_ok         = 1'b1;
  assign credit_cnt        = CREDIT_MAX;
  assign err_credit        = 1'b0;
`endif

endmodule

// File: tb/tb_ingress_pacer.sv
// Randomized + directed bench for ingress_pacer against a queue-based reference model and pulse scoreboard.
module tb_ingress_pacer;

  localparam int DEPTH   = 4;
  localparam int GAP     = 5;
  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);
  localparam int LW      = $clog2(DEPTH + 1);
`ifdef INGRESS_PACER_CREDIT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          credit_ret = 1'b0;
  logic [CW-1:0] credit_cnt;
  logic [LW-1:0] fifo_level;
  logic          err_credit;

  int vectors = 0;
  int miscompares = 0;

  ingress_pacer #(
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .credit_ret (credit_ret),
    .credit_cnt (credit_cnt),
    .fifo_level (fifo_level),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, credit count, and "edges since last issue" pacing rule.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         cr = CREDITS;
  bit         err = 1'b0;
  int         cyc = 0;
  int         last_issue = -1000;
  logic [7:0] mdat = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      cr = CREDITS;
      err = 1'b0;
      cyc = 0;
      last_issue = -1000;
      mdat = 8'h00;
    end else begin
      bit can;
      bit acc;
      cyc++;
      can = (mq.size() > 0) && (!CE || cr > 0) && (cyc - last_issue >= GAP);
      acc = s_valid && (mq.size() < DEPTH);
      if (CE && credit_ret && cr == CREDITS) err = 1'b1;
      if (can) begin
        mdat = mq.pop_front();
        exp_q.push_back(mdat);
        last_issue = cyc;
      end
      if (acc) mq.push_back(s_data);
      if (CE) begin
        if (can && !credit_ret) cr--;
        else if (!can && credit_ret && cr < CREDITS) cr++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pulse scoreboard plus per-cycle state comparison.
  always @(negedge clk) begin
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        chk("pulse_data", int'(m_data), int'(exp_q.pop_front()));
      end
    end else if (exp_q.size() != 0) begin
      chk("missing_pulse", 0, 1);
      void'(exp_q.pop_front());
    end
    chk("m_data_hold", int'(m_data), int'(mdat));
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("s_ready", int'(s_ready), int'(mq.size() < DEPTH));
    chk("credit_cnt", int'(credit_cnt), cr);
    chk("err_credit", int'(err_credit), int'(err));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    int g = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("push_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic ret();
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_credit", int'(credit_cnt), CREDITS);
    chk("rst_err", int'(err_credit), 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    push_byte(8'hA5);
    idle(10);
    ret();
    idle(2);
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    idle(25);
    for (int i = 0; i < 4; i++) begin
      ret();
      idle(2);
    end
    ret();
    idle(3);
    for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
    idle(30);
    ret();
    idle(10);
    for (int i = 0; i < 3; i++) push_byte(8'(8'h20 + i));
    idle(3);
    fork
      push_byte(8'h55);
      begin
        idle(10);
        ret();
      end
    join
    idle(40);
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'(8'h30 + i));
    do_reset();
    idle(2);
    push_byte(8'h77);
    idle(12);
    for (int ph = 0; ph < 8; ph++) begin
      int pv = $urandom_range(10, 95);
      int pr = $urandom_range(0, 40);
      for (int i = 0; i < 500; i++) begin
        s_valid    = ($urandom_range(0, 99) < pv);
        s_data     = 8'($urandom);
        credit_ret = ($urandom_range(0, 99) < pr);
        if ($urandom_range(0, 399) == 0) do_reset();
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    credit_ret = 1'b0;
    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
